// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: RV32 control-flow opcodes,
// lookup classification and the saturating counter step.
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Counters are handled in a 4-bit container so one step function covers every width.
    localparam int CTR_MAX_BITS = 4;

    typedef enum logic [1:0] {
        PK_NONE   = 2'd0,
        PK_BRANCH = 2'd1,
        PK_JUMP   = 2'd2
    } pred_kind_e;

    function automatic pred_kind_e classify(input logic [6:0] opcode);
        pred_kind_e kind;
        kind = PK_NONE;
        case (opcode)
            OPC_BRANCH:         kind = PK_BRANCH;
            OPC_JAL, OPC_JALR:  kind = PK_JUMP;
            default:            kind = PK_NONE;
        endcase
        return kind;
    endfunction

    function automatic logic [CTR_MAX_BITS-1:0] ctr_step(
        input logic [CTR_MAX_BITS-1:0] ctr,
        input logic                    up,
        input logic [CTR_MAX_BITS-1:0] ctr_max
    );
        logic [CTR_MAX_BITS-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != ctr_max) res = ctr + 4'd1;
        end else begin
            if (ctr != 4'd0) res = ctr - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_bpu_if.sv
// Lookup / resolve / statistics bundle between the fetch pipeline (master)
// and the gshare predictor (slave).
interface gshare_bpu_if #(
    parameter int PC_BITS  = 32,
    parameter int GHR_BITS = 8
);
    logic                pred_valid;
    logic [PC_BITS-1:0]  pred_pc;
    logic [6:0]          pred_opcode;
    logic                pred_taken;
    logic [GHR_BITS-1:0] pred_ghr;

    logic                upd_valid;
    logic [PC_BITS-1:0]  upd_pc;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                upd_taken;
    logic                upd_mispredict;

    logic [31:0]         stat_lookups;
    logic [31:0]         stat_mispredicts;

    modport master (
        output pred_valid, pred_pc, pred_opcode,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_taken, pred_ghr, stat_lookups, stat_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc, pred_opcode,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_taken, pred_ghr, stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2**IDX_BITS saturating counters with a combinational
// read port and a single training write port, all cleared asynchronously.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0]     INIT_VAL = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_MAX_BITS-1:0] CTR_MAX  = CTR_MAX_BITS'((1 << CTR_BITS) - 1);

    if (CTR_BITS < 1 || CTR_BITS > CTR_MAX_BITS) begin : g_bad_ctr_bits
        $error("bp_pht: CTR_BITS must be in 1..4");
    end

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [CTR_BITS-1:0] ctr_reg;
            logic                hit;

            assign hit = wr_en && (wr_idx == IDX_BITS'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_reg <= INIT_VAL;
                end else if (hit) begin
                    ctr_reg <= CTR_BITS'(ctr_step(CTR_MAX_BITS'(ctr_reg), wr_taken, CTR_MAX));
                end
            end

            assign ctr_q[gi] = ctr_reg;
        end
    endgenerate

    // Read returns the stored value; a same-cycle write is only visible after the edge.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/gshare_bpu.sv
// Gshare direction predictor: PC xor global history indexes the counter table;
// the speculative GHR is repaired from the caller's snapshot on a mispredict.
module gshare_bpu
    import bp_pkg::*;
#(
    parameter int PC_BITS  = 32,
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    gshare_bpu_if.slave  bus
);
    if (GHR_BITS > IDX_BITS) begin : g_bad_ghr_bits
        $error("gshare_bpu: GHR_BITS must not exceed IDX_BITS");
    end
    if (GHR_BITS < 2) begin : g_short_ghr
        $error("gshare_bpu: GHR_BITS must be at least 2");
    end
    if (PC_BITS < IDX_BITS + 3) begin : g_short_pc
        $error("gshare_bpu: PC_BITS too small for IDX_BITS");
    end

    logic [GHR_BITS-1:0] ghr_reg, ghr_next;
    logic [31:0]         lookups_reg, lookups_next;
    logic [31:0]         mispred_reg, mispred_next;
    pred_kind_e          kind;
    logic                is_branch;
    logic                recover;
    logic                taken;
    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [CTR_BITS-1:0] rd_ctr;

    assign kind      = bus.pred_valid ? classify(bus.pred_opcode) : PK_NONE;
    assign is_branch = (kind == PK_BRANCH);
    assign recover   = bus.upd_valid && bus.upd_mispredict;

    assign rd_idx = bus.pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_reg);
    assign wr_idx = bus.upd_pc[IDX_BITS+1:2]  ^ IDX_BITS'(bus.upd_ghr);

    bp_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS),
        .CTR_INIT (CTR_INIT)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (bus.upd_valid),
        .wr_idx   (wr_idx),
        .wr_taken (bus.upd_taken)
    );

    // Prediction is held low for the whole reset window, independent of the clock.
    always_comb begin
        taken = 1'b0;
        if (!rst) begin
            case (kind)
                PK_BRANCH: taken = rd_ctr[CTR_BITS-1];
                PK_JUMP:   taken = 1'b1;
                default:   taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        ghr_next     = ghr_reg;
        lookups_next = lookups_reg;
        mispred_next = mispred_reg;
        if (recover) begin
            ghr_next = {bus.upd_ghr[GHR_BITS-2:0], bus.upd_taken};
        end else if (is_branch) begin
            ghr_next = {ghr_reg[GHR_BITS-2:0], taken};
        end
        if (is_branch && (lookups_reg != 32'hFFFF_FFFF)) begin
            lookups_next = lookups_reg + 32'd1;
        end
        if (recover && (mispred_reg != 32'hFFFF_FFFF)) begin
            mispred_next = mispred_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg     <= '0;
            lookups_reg <= '0;
            mispred_reg <= '0;
        end else begin
            ghr_reg     <= ghr_next;
            lookups_reg <= lookups_next;
            mispred_reg <= mispred_next;
        end
    end

    assign bus.pred_taken       = taken;
    assign bus.pred_ghr         = ghr_reg;
    assign bus.stat_lookups     = lookups_reg;
    assign bus.stat_mispredicts = mispred_reg;

    // PC bits outside the hash window carry no prediction information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[PC_BITS-1:IDX_BITS+2], bus.pred_pc[1:0],
                              bus.upd_pc[PC_BITS-1:IDX_BITS+2], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_gshare_bpu.sv
// Random and directed stimulus for gshare_bpu, checked every cycle against a
// table/array model of the predictor plus hand-computed expectations.
module tb_gshare_bpu;

    localparam int PC_BITS  = 32;
    localparam int IDX_BITS = 8;
    localparam int GHR_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int CTR_INIT = 1;
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int IDX_MASK = ENTRIES - 1;
    localparam int GHR_MASK = (1 << GHR_BITS) - 1;
    localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF = 1 << (CTR_BITS - 1);

    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam longint     STAT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gshare_bpu_if #(.PC_BITS(PC_BITS), .GHR_BITS(GHR_BITS)) bus ();

    gshare_bpu #(
        .PC_BITS  (PC_BITS),
        .IDX_BITS (IDX_BITS),
        .GHR_BITS (GHR_BITS),
        .CTR_BITS (CTR_BITS),
        .CTR_INIT (CTR_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int     m_ctr [ENTRIES];
    int     m_ghr;
    longint m_lk;
    longint m_mp;

    // Current stimulus (bench copy)
    logic        s_pv, s_uv, s_ut, s_um;
    logic [31:0] s_pc, s_upc;
    logic [6:0]  s_op;
    logic [7:0]  s_ughr;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CTR_INIT;
        m_ghr = 0;
        m_lk  = 0;
        m_mp  = 0;
    endtask

    function automatic int model_pred();
        int idx;
        if (!s_pv) return 0;
        if (s_op == T_BRANCH) begin
            idx = (int'(s_pc >> 2) ^ m_ghr) & IDX_MASK;
            return (m_ctr[idx] >= CTR_HALF) ? 1 : 0;
        end
        if (s_op == T_JAL || s_op == T_JALR) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int pt;
        int ui;
        if (rst) begin
            model_reset();
            return;
        end
        pt = model_pred();
        if (s_uv) begin
            ui = (int'(s_upc >> 2) ^ int'(s_ughr)) & IDX_MASK;
            if (s_ut) begin
                if (m_ctr[ui] < CTR_MAX) m_ctr[ui]++;
            end else begin
                if (m_ctr[ui] > 0) m_ctr[ui]--;
            end
        end
        if (s_uv && s_um)
            m_ghr = ((int'(s_ughr) << 1) | int'(s_ut)) & GHR_MASK;
        else if (s_pv && s_op == T_BRANCH)
            m_ghr = ((m_ghr << 1) | pt) & GHR_MASK;
        if (s_pv && s_op == T_BRANCH && m_lk < STAT_MAX) m_lk++;
        if (s_uv && s_um && m_mp < STAT_MAX) m_mp++;
    endtask

    task automatic model_check(input string tag);
        int ep;
        ep = rst ? 0 : model_pred();
        check({tag, "/pred_taken"}, longint'(bus.pred_taken), longint'(ep));
        check({tag, "/pred_ghr"}, longint'(bus.pred_ghr), longint'(m_ghr));
        check({tag, "/stat_lookups"}, longint'(bus.stat_lookups), m_lk);
        check({tag, "/stat_mispredicts"}, longint'(bus.stat_mispredicts), m_mp);
    endtask

    // Called just after a rising edge; returns at the following falling edge after checking.
    task automatic run_cycle(input string tag,
                             input logic pv, input logic [31:0] pc, input logic [6:0] op,
                             input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                             input logic ut, input logic um);
        s_pv = pv; s_pc = pc; s_op = op;
        s_uv = uv; s_upc = upc; s_ughr = ughr; s_ut = ut; s_um = um;
        bus.pred_valid     = pv;
        bus.pred_pc        = pc;
        bus.pred_opcode    = op;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_ghr        = ughr;
        bus.upd_taken      = ut;
        bus.upd_mispredict = um;
        @(negedge clk);
        model_check(tag);
        $display("cyc %s pv=%0d pc=%08h op=%07b uv=%0d upc=%08h ughr=%02h t=%0d m=%0d -> taken=%0d ghr=%02h lk=%0d mp=%0d",
                 tag, pv, pc, op, uv, upc, ughr, ut, um,
                 bus.pred_taken, bus.pred_ghr, bus.stat_lookups, bus.stat_mispredicts);
    endtask

    task automatic end_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        run_cycle(tag, 1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    endtask

    // Reset pulse between the falling edge and the next rising edge.
    task automatic pulse_reset(input string tag, input bit pin_literals);
        #1 rst = 1'b1;
        #1;
        model_reset();
        model_check({tag, "/in_rst"});
        if (pin_literals) begin
            check("rst_pulse/pred_forced0", longint'(bus.pred_taken), 0);
            check("rst_pulse/ghr0", longint'(bus.pred_ghr), 0);
            check("rst_pulse/lookups0", longint'(bus.stat_lookups), 0);
            check("rst_pulse/mispred0", longint'(bus.stat_mispredicts), 0);
        end
        rst = 1'b0;
        #1;
        model_check({tag, "/after_rst"});
    endtask

    task automatic rand_cycle(input string tag);
        logic        pv, uv, ut, um;
        logic [31:0] pc, upc;
        logic [6:0]  op;
        logic [7:0]  ughr;
        int          sel;
        pv  = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        op  = (sel < 6) ? T_BRANCH : (sel == 6) ? T_JAL : (sel == 7) ? T_JALR : 7'($urandom);
        pc  = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 31)) << 2);
        uv  = ($urandom_range(0, 1) != 0);
        upc = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 31)) << 2);
        ughr = ($urandom_range(0, 1) != 0) ? 8'(m_ghr) : 8'($urandom);
        ut  = ($urandom_range(0, 1) != 0);
        um  = ($urandom_range(0, 3) == 0);
        run_cycle(tag, pv, pc, op, uv, upc, ughr, ut, um);
    endtask

    initial begin
        s_pv = 0; s_uv = 0; s_ut = 0; s_um = 0;
        s_pc = 0; s_upc = 0; s_op = 0; s_ughr = 0;
        bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_opcode = 0;
        bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_ghr = 0;
        bus.upd_taken = 0; bus.upd_mispredict = 0;
        model_reset();

        // Reset state, observed while rst is still high
        @(negedge clk);
        check("reset/pred_taken", longint'(bus.pred_taken), 0);
        check("reset/ghr", longint'(bus.pred_ghr), 0);
        check("reset/lookups", longint'(bus.stat_lookups), 0);
        check("reset/mispredicts", longint'(bus.stat_mispredicts), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // First BRANCH lookup at pc 0x40
        run_cycle("first_lookup", 1'b1, 32'h40, T_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("first_lookup/taken", longint'(bus.pred_taken), 0);
        check("first_lookup/ghr", longint'(bus.pred_ghr), 0);
        end_cycle();
        idle_cycle("after_first");
        check("after_first/lookups", longint'(bus.stat_lookups), 1);
        check("after_first/ghr", longint'(bus.pred_ghr), 0);
        end_cycle();

        // Train pc 0x40 / ghr 0 to saturation
        for (int i = 0; i < 4; i++) begin
            run_cycle("train", 1'b0, 32'h0, 7'h0, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
            end_cycle();
        end
        run_cycle("trained_lookup", 1'b1, 32'h40, T_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("trained_lookup/taken", longint'(bus.pred_taken), 1);
        end_cycle();
        run_cycle("fifth_update", 1'b0, 32'h0, 7'h0, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
        end_cycle();
        // GHR is now 1, so pc 0x44 hashes to the same entry (0x11 ^ 0x01 = 0x10)
        run_cycle("sat_lookup", 1'b1, 32'h44, T_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("sat_lookup/taken", longint'(bus.pred_taken), 1);
        end_cycle();
        run_cycle("one_down", 1'b0, 32'h0, 7'h0, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
        end_cycle();

        // Unconditional jumps
        run_cycle("jal", 1'b1, 32'h1234, T_JAL, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("jal/taken", longint'(bus.pred_taken), 1);
        end_cycle();
        run_cycle("jalr", 1'b1, 32'h5678, T_JALR, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("jalr/taken", longint'(bus.pred_taken), 1);
        end_cycle();
        idle_cycle("after_jumps");
        check("after_jumps/ghr", longint'(bus.pred_ghr), 8'h03);
        check("after_jumps/lookups", longint'(bus.stat_lookups), 3);
        end_cycle();

        // Recovery overrides a same-cycle speculative shift
        run_cycle("recover", 1'b1, 32'h100, T_BRANCH, 1'b1, 32'h200, 8'h5A, 1'b1, 1'b1);
        end_cycle();
        idle_cycle("after_recover");
        check("after_recover/ghr", longint'(bus.pred_ghr), 8'hB5);
        check("after_recover/mispredicts", longint'(bus.stat_mispredicts), 1);
        end_cycle();

        // Asynchronous reset between edges with a live lookup on the trained entry
        run_cycle("pre_rst", 1'b1, 32'h40, T_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        pulse_reset("rst_pulse", 1'b1);
        check("rst_pulse/ctr_init_read", longint'(bus.pred_taken), 0);
        end_cycle();

        // Same-entry lookup and update in one cycle: no bypass
        run_cycle("no_bypass", 1'b1, 32'h80, T_BRANCH, 1'b1, 32'h80, 8'h00, 1'b1, 1'b0);
        check("no_bypass/taken", longint'(bus.pred_taken), 0);
        end_cycle();
        run_cycle("after_bypass", 1'b1, 32'h80, T_BRANCH, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("after_bypass/taken", longint'(bus.pred_taken), 1);
        end_cycle();

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rand_cycle("rand");
            if (n % 500 == 250) begin
                pulse_reset("rand_pulse", 1'b0);
                end_cycle();
            end else if (n % 500 == 499) begin
                // Reset held across a rising edge: that edge must not update anything
                #1 rst = 1'b1;
                end_cycle();
                rand_cycle("rand_in_rst");
                #1 rst = 1'b0;
                end_cycle();
            end else begin
                end_cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
